bsg_manycore_store_tracker: RTL and testbench
=============================================

BSG_MANYCORE_STORE_TRACKER -- requirements
Module: bsg_manycore_store_tracker

Interface
REQ-001 SHALL have parameter num_classes_p, default 2, number of independently tracked request classes (≥1).
REQ-002 SHALL have parameter max_out_p, default 32, maximum outstanding requests per class (≥1); cnt_width_lp = $clog2(max_out_p+1), cls_width_lp = max(1,$clog2(num_classes_p)).
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_i  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 launch_v_i  input  1  outgoing remote request valid.
REQ-006 launch_class_i  input  cls_width_lp  class of launched request.
REQ-007 launch_ready_o  output  1  tracker accepts launch this cycle.
REQ-008 ret_v_i  input  1  return (credit) packet arrival; always accepted.
REQ-009 ret_class_i  input  cls_width_lp  class of returned credit.
REQ-010 fence_v_i  input  1  fence request valid.
REQ-011 fence_mask_i  input  num_classes_p  classes the fence waits on.
REQ-012 fence_ready_o  output  1  fence accepted when fence_v_i & fence_ready_o.
REQ-013 fence_done_o  output  1  one-cycle pulse: fence completed.
REQ-014 count_o  output  num_classes_p*cnt_width_lp  per-class outstanding count, class 0 in LSBs.
REQ-015 err_o  output  1  sticky underflow error.
REQ-016 err_class_o  output  cls_width_lp  class of first underflow.
REQ-017 err_clear_i  input  1  clears err_o/err_class_o.

Function
REQ-018 Launch accepted iff launch_v_i & launch_ready_o; launch_ready_o = (count[launch_class_i] != max_out_p) & (state != FENCE_WAIT); combinational, independent of launch_v_i.
REQ-019 Accepted launch increments count[launch_class_i] next edge; returns decrement count[ret_class_i] next edge; count_o is registered.
REQ-020 Accepted launch and return on the same class in one cycle: count unchanged; on different classes: each updated independently.
REQ-021 Return to a class with count 0 (and no same-cycle accepted launch on that class): count stays 0, err_o set next edge; err_class_o captured only if err_o was 0.
REQ-022 Counts never wrap: saturation prevented by launch_ready_o; no other path above max_out_p.
REQ-023 Out-of-range class index (≥ num_classes_p): launch not accepted (launch_ready_o=0), return ignored and flags underflow with that index.
REQ-024 FSM states IDLE, FENCE_WAIT; fence_ready_o = (state == IDLE).
REQ-025 IDLE: accepted fence -> if all masked counts (post-update, including same-cycle launch/return) are zero, fence_done_o=1 next cycle and stay IDLE; else latch mask, go FENCE_WAIT.
REQ-026 FENCE_WAIT: launches blocked on all classes; when all latched-mask counts are zero (registered values), assert fence_done_o that cycle and return to IDLE next edge.
REQ-027 Fence with mask all-zero completes with fence_done_o one cycle after acceptance.
REQ-028 err_clear_i clears err_o next edge; simultaneous new underflow wins (err_o stays 1, err_class_o = new class).
REQ-029 fence_done_o is a single-cycle pulse per accepted fence; no pulse without an accepted fence.

Reset
REQ-030 While reset_i=0: all counts 0, state IDLE, latched mask 0, err_o=0, err_class_o=0, fence_done_o=0, immediately (asynchronously).
REQ-031 Reset asserted mid-FENCE_WAIT aborts the fence with no fence_done_o pulse; launch_ready_o=1 and fence_ready_o=1 after release.

Verification
REQ-032 num_classes_p=2, max_out_p=4: 4 launches class 0 -> count0=4, launch_ready_o=0 for class 0, 1 for class 1; one return class 0 -> count0=3, ready=1.
REQ-033 count1=2; same-cycle launch+return class 1 -> count1=2; launch class 0 + return class 1 -> count0+1, count1=1.
REQ-034 count0=0, ret_v_i class 0 -> count0=0, err_o=1, err_class_o=0; second underflow class 1 -> err_class_o stays 0; err_clear_i -> err_o=0.
REQ-035 count0=2, fence mask=01 -> FENCE_WAIT, launch_ready_o=0; two returns -> fence_done_o one pulse, IDLE, ready restored.
REQ-036 Fence mask=00 or all masked counts 0 -> fence_done_o exactly one cycle after acceptance.
REQ-037 reset_i driven low mid-FENCE_WAIT with count0=3 -> counts 0, no fence_done_o, IDLE after release.

Source files
------------

// File: rtl/bsg_manycore_store_tracker.sv
// rtl/bsg_manycore_store_tracker.sv - per-class outstanding remote store tracker with fence and underflow error
module bsg_manycore_store_tracker #(
    parameter int num_classes_p = 2,
    parameter int max_out_p     = 32,
    localparam int cnt_width_lp = $clog2(max_out_p + 1),
    localparam int cls_width_lp = (num_classes_p > 1) ? $clog2(num_classes_p) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  launch_v_i,
    input  logic [cls_width_lp-1:0]               launch_class_i,
    output logic                                  launch_ready_o,
    input  logic                                  ret_v_i,
    input  logic [cls_width_lp-1:0]               ret_class_i,
    input  logic                                  fence_v_i,
    input  logic [num_classes_p-1:0]              fence_mask_i,
    output logic                                  fence_ready_o,
    output logic                                  fence_done_o,
    output logic [num_classes_p*cnt_width_lp-1:0] count_o,
    output logic                                  err_o,
    output logic [cls_width_lp-1:0]               err_class_o,
    input  logic                                  err_clear_i
);

    typedef enum logic {
        IDLE,
        FENCE_WAIT
    } state_e;

    state_e                    state_q, state_d;
    logic [num_classes_p-1:0]  mask_q, mask_d;
    logic                      err_q, err_d;
    logic [cls_width_lp-1:0]   err_class_q, err_class_d;
    logic                      done_q, done_d;
    logic [cnt_width_lp-1:0]   cnt_q [num_classes_p];
    logic [cnt_width_lp-1:0]   cnt_d [num_classes_p];

    logic [num_classes_p-1:0]  launch_sel, ret_sel;
    logic [num_classes_p-1:0]  cnt_full, cnt_zero, nonzero_d, launch_hit;
    logic                      launch_acc, ret_uf, post_zero, wait_zero;

    // One-hot class decode; an out-of-range index decodes to all zeros.
    always_comb begin
        launch_sel = '0;
        ret_sel    = '0;
        cnt_full   = '0;
        cnt_zero   = '0;
        for (int c = 0; c < num_classes_p; c++) begin
            launch_sel[c] = (launch_class_i == cls_width_lp'(c));
            ret_sel[c]    = (ret_class_i == cls_width_lp'(c));
            cnt_full[c]   = (cnt_q[c] == cnt_width_lp'(max_out_p));
            cnt_zero[c]   = (cnt_q[c] == '0);
        end
    end

    assign launch_ready_o = (|(launch_sel & ~cnt_full)) && (state_q == IDLE);
    assign launch_acc     = launch_v_i & launch_ready_o;
    assign launch_hit     = launch_sel & {num_classes_p{launch_acc}};
    assign ret_uf         = ret_v_i & ((~|ret_sel) | (|(ret_sel & cnt_zero & ~launch_hit)));

    always_comb begin
        nonzero_d = '0;
        for (int c = 0; c < num_classes_p; c++) begin
            cnt_d[c] = cnt_q[c];
            if (launch_hit[c] && !(ret_v_i && ret_sel[c])) begin
                cnt_d[c] = cnt_q[c] + cnt_width_lp'(1);
            end else if (!launch_hit[c] && ret_v_i && ret_sel[c] && !cnt_zero[c]) begin
                cnt_d[c] = cnt_q[c] - cnt_width_lp'(1);
            end
            nonzero_d[c] = (cnt_d[c] != '0);
        end
    end

    assign post_zero = ~|(fence_mask_i & nonzero_d);
    assign wait_zero = ~|(mask_q & ~cnt_zero);

    // A clear in the same cycle as a new underflow loses to the underflow.
    always_comb begin
        err_d       = err_q;
        err_class_d = err_class_q;
        if (err_clear_i) begin
            err_d       = 1'b0;
            err_class_d = '0;
        end
        if (ret_uf) begin
            err_d = 1'b1;
            if (!err_q || err_clear_i) begin
                err_class_d = ret_class_i;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        done_d       = 1'b0;
        fence_done_o = done_q;
        case (state_q)
            IDLE: begin
                if (fence_v_i) begin
                    if (post_zero) begin
                        done_d = 1'b1;
                    end else begin
                        mask_d  = fence_mask_i;
                        state_d = FENCE_WAIT;
                    end
                end
            end
            FENCE_WAIT: begin
                if (wait_zero) begin
                    fence_done_o = 1'b1;
                    mask_d       = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fence_ready_o = (state_q == IDLE);
    assign err_o         = err_q;
    assign err_class_o   = err_class_q;

    always_comb begin
        count_o = '0;
        for (int c = 0; c < num_classes_p; c++) begin
            count_o[c*cnt_width_lp +: cnt_width_lp] = cnt_q[c];
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            err_q       <= 1'b0;
            err_class_q <= '0;
            done_q      <= 1'b0;
            for (int c = 0; c < num_classes_p; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
            err_class_q <= err_class_d;
            done_q      <= done_d;
            for (int c = 0; c < num_classes_p; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

endmodule

// File: tb/tb_bsg_manycore_store_tracker.sv
// tb/tb_bsg_manycore_store_tracker.sv - directed-vector bench for bsg_manycore_store_tracker (2 classes, depth 4)
module tb_bsg_manycore_store_tracker;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       launch_v_i;
    logic [0:0] launch_class_i;
    logic       launch_ready_o;
    logic       ret_v_i;
    logic [0:0] ret_class_i;
    logic       fence_v_i;
    logic [1:0] fence_mask_i;
    logic       fence_ready_o;
    logic       fence_done_o;
    logic [5:0] count_o;
    logic       err_o;
    logic [0:0] err_class_o;
    logic       err_clear_i;

    int n_vec = 0;
    int n_bad = 0;

    bsg_manycore_store_tracker #(.num_classes_p(2), .max_out_p(4)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .launch_v_i     (launch_v_i),
        .launch_class_i (launch_class_i),
        .launch_ready_o (launch_ready_o),
        .ret_v_i        (ret_v_i),
        .ret_class_i    (ret_class_i),
        .fence_v_i      (fence_v_i),
        .fence_mask_i   (fence_mask_i),
        .fence_ready_o  (fence_ready_o),
        .fence_done_o   (fence_done_o),
        .count_o        (count_o),
        .err_o          (err_o),
        .err_class_o    (err_class_o),
        .err_clear_i    (err_clear_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        launch_v_i  = 1'b0;
        ret_v_i     = 1'b0;
        fence_v_i   = 1'b0;
        err_clear_i = 1'b0;
        #1;
    endtask

    initial begin
        reset_i        = 1'b0;
        launch_v_i     = 1'b0;
        launch_class_i = 1'b0;
        ret_v_i        = 1'b0;
        ret_class_i    = 1'b0;
        fence_v_i      = 1'b0;
        fence_mask_i   = 2'b00;
        err_clear_i    = 1'b0;
        #1;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_done", 32'(fence_done_o), 32'd0);
        chk("rst_lready", 32'(launch_ready_o), 32'd1);
        chk("rst_fready", 32'(fence_ready_o), 32'd1);
        cyc(); cyc();
        reset_i = 1'b1;
        cyc();

        // Fill class 0; the fifth launch must be refused.
        launch_v_i = 1'b1; launch_class_i = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        idle_in();
        chk("fill_count0", 32'(count_o[2:0]), 32'd4);
        chk("full_ready0", 32'(launch_ready_o), 32'd0);
        launch_class_i = 1'b1; #1;
        chk("full_ready1", 32'(launch_ready_o), 32'd1);
        ret_v_i = 1'b1; ret_class_i = 1'b0; cyc(); idle_in();
        launch_class_i = 1'b0; #1;
        chk("ret_count0", 32'(count_o[2:0]), 32'd3);
        chk("ret_ready0", 32'(launch_ready_o), 32'd1);

        // Same-class and cross-class launch/return pairs.
        launch_v_i = 1'b1; launch_class_i = 1'b1; cyc(); cyc(); idle_in();
        chk("count1_two", 32'(count_o[5:3]), 32'd2);
        launch_v_i = 1'b1; launch_class_i = 1'b1; ret_v_i = 1'b1; ret_class_i = 1'b1; cyc(); idle_in();
        chk("same_cls_pair", 32'(count_o), {26'd0, 3'd2, 3'd3});
        launch_v_i = 1'b1; launch_class_i = 1'b0; ret_v_i = 1'b1; ret_class_i = 1'b1; cyc(); idle_in();
        chk("cross_cls_pair", 32'(count_o), {26'd0, 3'd1, 3'd4});
        chk("no_err_yet", 32'(err_o), 32'd0);

        // Drain everything.
        ret_v_i = 1'b1; ret_class_i = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        ret_class_i = 1'b1; cyc(); idle_in();
        chk("drained", 32'(count_o), 32'd0);

        // Underflow, sticky class, clear, clear-vs-new-underflow.
        ret_v_i = 1'b1; ret_class_i = 1'b0; cyc(); idle_in();
        chk("uf0_err", 32'(err_o), 32'd1);
        chk("uf0_class", 32'(err_class_o), 32'd0);
        chk("uf0_count", 32'(count_o), 32'd0);
        ret_v_i = 1'b1; ret_class_i = 1'b1; cyc(); idle_in();
        chk("uf1_class_kept", 32'(err_class_o), 32'd0);
        err_clear_i = 1'b1; cyc(); idle_in();
        chk("clr_err", 32'(err_o), 32'd0);
        err_clear_i = 1'b1; ret_v_i = 1'b1; ret_class_i = 1'b1; cyc(); idle_in();
        chk("clr_vs_uf_err", 32'(err_o), 32'd1);
        chk("clr_vs_uf_class", 32'(err_class_o), 32'd1);
        err_clear_i = 1'b1; cyc(); idle_in();
        chk("clr2_err", 32'(err_o), 32'd0);
        chk("clr2_class", 32'(err_class_o), 32'd0);

        // Fence waiting on class 0 with two outstanding.
        launch_v_i = 1'b1; launch_class_i = 1'b0; cyc(); cyc(); idle_in();
        fence_v_i = 1'b1; fence_mask_i = 2'b01; #1;
        chk("fence_rdy_idle", 32'(fence_ready_o), 32'd1);
        cyc(); idle_in();
        chk("fw_fready", 32'(fence_ready_o), 32'd0);
        chk("fw_lready0", 32'(launch_ready_o), 32'd0);
        launch_class_i = 1'b1; #1;
        chk("fw_lready1", 32'(launch_ready_o), 32'd0);
        chk("fw_done_early", 32'(fence_done_o), 32'd0);
        ret_v_i = 1'b1; ret_class_i = 1'b0; cyc();
        chk("fw_done_mid", 32'(fence_done_o), 32'd0);
        cyc(); idle_in();
        chk("fw_done", 32'(fence_done_o), 32'd1);
        cyc();
        chk("fw_done_once", 32'(fence_done_o), 32'd0);
        chk("fw_back_fready", 32'(fence_ready_o), 32'd1);
        chk("fw_back_lready", 32'(launch_ready_o), 32'd1);

        // Empty-mask fence: pulse exactly one cycle after acceptance.
        fence_v_i = 1'b1; fence_mask_i = 2'b00; #1;
        chk("m0_done_acc", 32'(fence_done_o), 32'd0);
        cyc(); idle_in();
        chk("m0_done", 32'(fence_done_o), 32'd1);
        chk("m0_fready", 32'(fence_ready_o), 32'd1);
        cyc();
        chk("m0_done_once", 32'(fence_done_o), 32'd0);

        // Same-cycle launch on a masked class makes the fence wait.
        fence_v_i = 1'b1; fence_mask_i = 2'b10; launch_v_i = 1'b1; launch_class_i = 1'b1; cyc(); idle_in();
        chk("post_upd_wait", 32'(fence_ready_o), 32'd0);
        chk("post_upd_cnt1", 32'(count_o[5:3]), 32'd1);
        chk("post_upd_nodone", 32'(fence_done_o), 32'd0);
        ret_v_i = 1'b1; ret_class_i = 1'b1; cyc(); idle_in();
        chk("post_upd_done", 32'(fence_done_o), 32'd1);
        cyc();
        chk("post_upd_once", 32'(fence_done_o), 32'd0);

        // Unmasked outstanding class does not hold the fence.
        launch_v_i = 1'b1; launch_class_i = 1'b0; cyc(); idle_in();
        fence_v_i = 1'b1; fence_mask_i = 2'b10; cyc(); idle_in();
        chk("unmasked_done", 32'(fence_done_o), 32'd1);
        chk("unmasked_cnt0", 32'(count_o[2:0]), 32'd1);
        ret_v_i = 1'b1; ret_class_i = 1'b0; cyc(); idle_in();
        chk("unmasked_once", 32'(fence_done_o), 32'd0);

        // Reset in the middle of a fence wait.
        launch_v_i = 1'b1; launch_class_i = 1'b0; cyc(); cyc(); cyc(); idle_in();
        fence_v_i = 1'b1; fence_mask_i = 2'b01; cyc(); idle_in();
        chk("rfw_wait", 32'(fence_ready_o), 32'd0);
        chk("rfw_cnt0", 32'(count_o[2:0]), 32'd3);
        #1; reset_i = 1'b0; #1;
        chk("rfw_async_cnt", 32'(count_o), 32'd0);
        chk("rfw_async_fready", 32'(fence_ready_o), 32'd1);
        chk("rfw_async_done", 32'(fence_done_o), 32'd0);
        cyc();
        reset_i = 1'b1;
        cyc();
        chk("rfw_rel_done", 32'(fence_done_o), 32'd0);
        chk("rfw_rel_lready", 32'(launch_ready_o), 32'd1);
        chk("rfw_rel_fready", 32'(fence_ready_o), 32'd1);
        chk("rfw_rel_err", 32'(err_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
